// File: rtl/arbitro_memoria_datos_if.sv
// arbitro_memoria_datos_if: requester handshake and shared data-memory bus of the arbiter
interface arbitro_memoria_datos_if #(
  parameter int Ancho_Dato      = 32,
  parameter int Ancho_Direccion = 32
);
  logic                       sol_a, sol_b;
  logic                       esc_a, esc_b;
  logic [Ancho_Direccion-1:0] dir_a, dir_b;
  logic [Ancho_Dato-1:0]      dato_a, dato_b;
  logic                       ack_a, ack_b;
  logic                       err_a, err_b;
  logic [Ancho_Dato-1:0]      lect_a, lect_b;
  logic                       mem_escritura_habilitada, mem_lectura_habilitada;
  logic [Ancho_Direccion-1:0] mem_direccion;
  logic [Ancho_Dato-1:0]      mem_dato_escritura, mem_dato_lectura;
  // master: requesters plus the memory returning read data
  modport master (
    output sol_a, sol_b, esc_a, esc_b, dir_a, dir_b, dato_a, dato_b, mem_dato_lectura,
    input  ack_a, ack_b, err_a, err_b, lect_a, lect_b,
    input  mem_escritura_habilitada, mem_lectura_habilitada, mem_direccion, mem_dato_escritura
  );
  modport slave (
    input  sol_a, sol_b, esc_a, esc_b, dir_a, dir_b, dato_a, dato_b, mem_dato_lectura,
    output ack_a, ack_b, err_a, err_b, lect_a, lect_b,
    output mem_escritura_habilitada, mem_lectura_habilitada, mem_direccion, mem_dato_escritura
  );
endinterface

// File: rtl/arbitro_memoria_datos.sv
// arbitro_memoria_datos: round-robin arbiter giving two requesters single-cycle access to one data memory
module arbitro_memoria_datos #(
  parameter int Ancho_Dato      = 32,
  parameter int Ancho_Direccion = 32,
  parameter int Tamanio_Mem     = 256
) (
  input logic                    clk,
  input logic                    rst_n,
  arbitro_memoria_datos_if.slave bus
);
  typedef enum logic [1:0] {REPOSO, ACCESO, RESPUESTA} estado_t;
  localparam logic [Ancho_Direccion-1:0] LIMITE = Ancho_Direccion'(Tamanio_Mem);
  estado_t                    estado;
  logic                       ptr_b, gan_b, r_esc, r_err;
  logic [Ancho_Direccion-1:0] r_dir;
  logic [Ancho_Dato-1:0]      r_dato;
  logic                       elige_b, err_sel, acc;
  logic [Ancho_Direccion-1:0] dir_sel;
  // ptr_b = 1 means B was served last, so A wins a tie
  always_comb begin
    elige_b = bus.sol_b && (!bus.sol_a || !ptr_b);
    dir_sel = elige_b ? bus.dir_b : bus.dir_a;
    err_sel = (dir_sel[1:0] != 2'b00) || ((dir_sel >> 2) >= LIMITE);
    acc     = rst_n && (estado == ACCESO) && !r_err;
  end
  assign bus.mem_escritura_habilitada = acc && r_esc;
  assign bus.mem_lectura_habilitada   = acc && !r_esc;
  assign bus.mem_direccion            = acc ? r_dir : '0;
  assign bus.mem_dato_escritura       = acc ? r_dato : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= REPOSO;
      ptr_b      <= 1'b1;
      gan_b      <= 1'b0;
      r_esc      <= 1'b0;
      r_err      <= 1'b0;
      r_dir      <= '0;
      r_dato     <= '0;
      bus.ack_a  <= 1'b0;
      bus.ack_b  <= 1'b0;
      bus.err_a  <= 1'b0;
      bus.err_b  <= 1'b0;
      bus.lect_a <= '0;
      bus.lect_b <= '0;
    end else begin
      bus.ack_a <= 1'b0;
      bus.ack_b <= 1'b0;
      bus.err_a <= 1'b0;
      bus.err_b <= 1'b0;
      case (estado)
        REPOSO: if (bus.sol_a || bus.sol_b) begin
          gan_b  <= elige_b;
          ptr_b  <= elige_b;
          r_esc  <= elige_b ? bus.esc_b : bus.esc_a;
          r_dir  <= dir_sel;
          r_dato <= elige_b ? bus.dato_b : bus.dato_a;
          r_err  <= err_sel;
          estado <= ACCESO;
        end
        ACCESO: begin
          if (!r_err && !r_esc && !gan_b) bus.lect_a <= bus.mem_dato_lectura;
          if (!r_err && !r_esc && gan_b) bus.lect_b <= bus.mem_dato_lectura;
          bus.ack_a <= !gan_b;
          bus.ack_b <= gan_b;
          bus.err_a <= !gan_b && r_err;
          bus.err_b <= gan_b && r_err;
          estado    <= RESPUESTA;
        end
        default: estado <= REPOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// tb_arbitro_memoria_datos: directed checks of arbitration, latency, error handling and reset abort
module tb_arbitro_memoria_datos;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int n_we = 0, n_re = 0, n_rst_en = 0;
  int t_k, ka, kb, w0, r0, nack;
  logic t_err, t_we, t_re;
  logic [31:0] t_addr;
  int ord[$];
  int tim[$];
  logic [31:0] mem [256] = '{default: 32'h0};

  arbitro_memoria_datos_if #(.Ancho_Dato(32), .Ancho_Direccion(32)) bus ();
  arbitro_memoria_datos #(.Ancho_Dato(32), .Ancho_Direccion(32), .Tamanio_Mem(256)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  assign bus.mem_dato_lectura = mem[bus.mem_direccion[9:2]];
  always @(posedge clk) if (bus.mem_escritura_habilitada) mem[bus.mem_direccion[9:2]] <= bus.mem_dato_escritura;
  always @(negedge clk) begin
    if (bus.mem_escritura_habilitada) n_we++;
    if (bus.mem_lectura_habilitada) n_re++;
    if (!rst_n && (bus.mem_escritura_habilitada || bus.mem_lectura_habilitada)) n_rst_en++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit b, input bit esc, input logic [31:0] dir, input logic [31:0] dato);
    @(negedge clk);
    if (b) begin bus.sol_b = 1'b1; bus.esc_b = esc; bus.dir_b = dir; bus.dato_b = dato; end
    else begin bus.sol_a = 1'b1; bus.esc_a = esc; bus.dir_a = dir; bus.dato_a = dato; end
    t_k = 0; t_err = 1'bx; t_we = 1'b0; t_re = 1'b0; t_addr = '1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        t_we = bus.mem_escritura_habilitada; t_re = bus.mem_lectura_habilitada; t_addr = bus.mem_direccion;
      end
      if (b ? bus.ack_b : bus.ack_a) begin
        t_k = k; t_err = b ? bus.err_b : bus.err_a;
        break;
      end
    end
    if (b) bus.sol_b = 1'b0; else bus.sol_a = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.sol_a = 0; bus.sol_b = 0; bus.esc_a = 0; bus.esc_b = 0;
    bus.dir_a = 0; bus.dir_b = 0; bus.dato_a = 0; bus.dato_b = 0;
    repeat (3) @(negedge clk);
    chk("reset_ack", {bus.ack_a, bus.ack_b, bus.err_a, bus.err_b}, 4'h0);
    chk("reset_lect_a", bus.lect_a, 32'h0);
    chk("reset_lect_b", bus.lect_b, 32'h0);
    chk("reset_mem_out", {bus.mem_escritura_habilitada, bus.mem_lectura_habilitada, bus.mem_direccion, bus.mem_dato_escritura}, 66'h0);
    rst_n = 1'b1;
    // single write by A, then single read by B
    w0 = n_we;
    txn(0, 1, 32'h0, 32'hDEADBEEF);
    chk("wr_a_we", t_we, 1'b1);
    chk("wr_a_addr", t_addr, 32'h0);
    chk("wr_a_lat", t_k, 2);
    chk("wr_a_err", t_err, 1'b0);
    chk("wr_a_we_pulses", n_we - w0, 1);
    chk("wr_a_mem", mem[0], 32'hDEADBEEF);
    r0 = n_re;
    txn(1, 0, 32'h0, 32'h0);
    chk("rd_b_lat", t_k, 2);
    chk("rd_b_err", t_err, 1'b0);
    chk("rd_b_re", n_re - r0, 1);
    chk("rd_b_lect", bus.lect_b, 32'hDEADBEEF);
    chk("rd_b_lect_a_kept", bus.lect_a, 32'h0);
    // simultaneous requests right after reset: A first
    reset_dut();
    @(negedge clk);
    bus.sol_a = 1; bus.esc_a = 1; bus.dir_a = 32'h4; bus.dato_a = 32'hCAFEBABE;
    bus.sol_b = 1; bus.esc_b = 0; bus.dir_b = 32'h4; bus.dato_b = 32'h0;
    ka = 0; kb = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.ack_a && ka == 0) begin ka = k; bus.sol_a = 0; end
      if (bus.ack_b && kb == 0) begin kb = k; bus.sol_b = 0; end
    end
    chk("tie_a_lat", ka, 2);
    chk("tie_b_lat", kb, 5);
    chk("tie_lect_b", bus.lect_b, 32'hCAFEBABE);
    // both held high for four transactions
    @(negedge clk);
    bus.sol_a = 1; bus.esc_a = 0; bus.dir_a = 32'h4;
    bus.sol_b = 1; bus.esc_b = 0; bus.dir_b = 32'h0;
    ord.delete(); tim.delete();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ack_a) begin ord.push_back(0); tim.push_back(k); end
      if (bus.ack_b) begin ord.push_back(1); tim.push_back(k); end
    end
    bus.sol_a = 0; bus.sol_b = 0;
    chk("rr_count", ord.size(), 4);
    if (ord.size() == 4) begin
      chk("rr_order", {ord[0][0], ord[1][0], ord[2][0], ord[3][0]}, 4'b0101);
      chk("rr_times", {tim[0][7:0], tim[1][7:0], tim[2][7:0], tim[3][7:0]}, {8'd2, 8'd5, 8'd8, 8'd11});
    end
    chk("rr_lect_a", bus.lect_a, 32'hCAFEBABE);
    chk("rr_lect_b", bus.lect_b, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    // address range and alignment errors
    txn(0, 1, 32'h3FC, 32'h11112222);
    chk("top_err", t_err, 1'b0);
    w0 = n_we; r0 = n_re;
    txn(0, 1, 32'h400, 32'h99999999);
    chk("oor_err", t_err, 1'b1);
    chk("oor_lat", t_k, 2);
    txn(0, 1, 32'h2, 32'h99999999);
    chk("unal_err", t_err, 1'b1);
    chk("err_no_enable", (n_we - w0) + (n_re - r0), 0);
    txn(0, 0, 32'h3FC, 32'h0);
    chk("top_read", bus.lect_a, 32'h11112222);
    txn(1, 0, 32'h401, 32'h0);
    chk("err_b", t_err, 1'b1);
    chk("err_b_lect_kept", bus.lect_b, 32'hDEADBEEF);
    // reset during the access cycle of a write
    txn(0, 1, 32'h10, 32'hAAAA0000);
    w0 = n_we;
    @(negedge clk);
    bus.sol_a = 1; bus.esc_a = 1; bus.dir_a = 32'h10; bus.dato_a = 32'h12345678;
    @(posedge clk); #1;
    rst_n = 1'b0; bus.sol_a = 0;
    @(negedge clk);
    chk("abort_we", bus.mem_escritura_habilitada, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.ack_a || bus.ack_b) nack++;
    end
    chk("abort_no_ack", nack, 0);
    chk("abort_no_write", n_we - w0, 0);
    txn(0, 0, 32'h10, 32'h0);
    chk("abort_old_value", bus.lect_a, 32'hAAAA0000);
    chk("no_enable_in_reset", n_rst_en, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arbitro_memoria_datos.md
ARBITRO_MEMORIA_DATOS -- requirements
Module: arbitro_memoria_datos

Interface
REQ-001 Parameter Ancho_Dato, default 32: data width of memory and requester data ports.
REQ-002 Parameter Ancho_Direccion, default 32: byte-address width.
REQ-003 Parameter Tamanio_Mem, default 256: number of words in the shared memoria_datos.
REQ-004 Single clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock shared with memoria_datos.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 sol_a / sol_b  in  1  access request from requester A / B.
REQ-008 esc_a / esc_b  in  1  1 = write, 0 = read.
REQ-009 dir_a / dir_b  in  Ancho_Direccion  byte address.
REQ-010 dato_a / dato_b  in  Ancho_Dato  write data.
REQ-011 ack_a / ack_b  out  1  one-cycle completion pulse.
REQ-012 err_a / err_b  out  1  error flag, meaningful only while the matching ack is 1.
REQ-013 lect_a / lect_b  out  Ancho_Dato  registered read data.
REQ-014 mem_escritura_habilitada, mem_lectura_habilitada  out  1  memory enables.
REQ-015 mem_direccion  out  Ancho_Direccion; mem_dato_escritura  out  Ancho_Dato  memory address and write data.
REQ-016 mem_dato_lectura  in  Ancho_Dato  combinational read data from memory.

Function
REQ-017 FSM states: REPOSO, ACCESO, RESPUESTA; ACCESO and RESPUESTA each last exactly one cycle.
REQ-018 REPOSO: with no sol asserted, stay. With exactly one asserted, grant it. With both asserted, grant the requester not served last (round-robin pointer).
REQ-019 On grant, register esc, dir and dato of the winner plus the winner identity, update the pointer to the winner, and move to ACCESO.
REQ-020 ACCESO: drive mem_direccion and mem_dato_escritura from the registered request. Assert mem_escritura_habilitada if esc=1, otherwise mem_lectura_habilitada.
REQ-021 ACCESO, reads: capture mem_dato_lectura into the winner's lect register at the end of the cycle. Move to RESPUESTA.
REQ-022 RESPUESTA: ack of the winner = 1 for that cycle only, err set per REQ-024. Return to REPOSO.
REQ-023 Latency: sol sampled in REPOSO at edge N means the memory access occurs in cycle N+1 and ack is high in cycle N+2. Maximum throughput is one access per 3 cycles.
REQ-024 Error when dir[1:0] != 0 or (dir >> 2) >= Tamanio_Mem. In that case, no memory enable in ACCESO, err = 1 with ack, and lect is unchanged.
REQ-025 Outside ACCESO, and for errored requests, both mem enables are 0 and mem_direccion and mem_dato_escritura are 0.
REQ-026 Requester holds sol and its fields stable until its ack. Fields are sampled only at grant. sol still high in the cycle after ack is a new request.
REQ-027 The other requester's ack, err and lect are never disturbed. lect_x holds its value until the next successful read by x.
REQ-028 A requester stalls at most one other access while requesting; starvation is not possible.

Reset
REQ-029 rst_n = 0 at a rising edge sets: state REPOSO, pointer = B (A wins first tie), lect_a = lect_b = 0, ack and err = 0, all registered request fields 0.
REQ-030 Both mem enables are gated combinationally by rst_n, so no write occurs at an edge where rst_n = 0, including mid-ACCESO. An interrupted transaction produces no ack.

Verification
REQ-031 A writes 0xDEADBEEF to 0x00 (idle B) -> mem_escritura_habilitada high exactly one cycle with mem_direccion = 0x00; ack_a 2 cycles after sampling, err_a = 0.
REQ-032 B reads 0x00 afterwards -> lect_b = 0xDEADBEEF at ack_b; lect_a unchanged.
REQ-033 sol_a and sol_b raised together after reset, A writing 0xCAFEBABE to 0x04 and B reading 0x04 -> A served first, B second; lect_b = 0xCAFEBABE; acks 3 cycles apart.
REQ-034 Both held high for 4 transactions -> grant order A,B,A,B; no back-to-back grant to one side.
REQ-035 A writes to 0x3FC -> success. A writes to 0x400 or 0x02 -> err_a = 1, no memory enable pulse, and a subsequent read of 0x3FC returns the prior 0x3FC data.
REQ-036 rst_n dropped during the ACCESO cycle of a write of 0x12345678 to 0x10 -> no enable while reset, no ack. A read of 0x10 after reset returns the old value.
